// File: rtl/seg_scan_if.sv
// Digit inputs and display outputs of the four-digit 7-segment scanner.
// The master side feeds the BCD digits; the slave side is the display driver.
interface seg_scan_if;
    logic       en;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] dp_mask;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [3:0] dig_sel;
    logic       frame_tick;

    modport master (
        output en, digit0, digit1, digit2, digit3, dp_mask,
        input  seg_out, dp_out, dig_sel, frame_tick
    );

    modport slave (
        input  en, digit0, digit1, digit2, digit3, dp_mask,
        output seg_out, dp_out, dig_sel, frame_tick
    );
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment driver: per-frame digit snapshot, leading-zero
// blanking, ghost-suppression gap at each digit switch, active-low outputs.
//
// state | meaning
// SLOT0 | scanning digit0 (rightmost)
// SLOT1 | scanning digit1
// SLOT2 | scanning digit2
// SLOT3 | scanning digit3; its last cycle loads the next snapshot
module seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic      clk,
    input  logic      sys_rst_n,
    seg_scan_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_TH = CNT_W'(BLANK_CYC);

    typedef enum logic [1:0] {SLOT0 = 2'd0, SLOT1 = 2'd1, SLOT2 = 2'd2, SLOT3 = 2'd3} slot_t;

    slot_t            r_idx;
    slot_t            w_idx_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0][3:0]  r_snap;
    logic [3:0]       r_dp_snap;
    logic [6:0]       r_seg_out;
    logic             r_dp_out;
    logic [3:0]       r_dig_sel;
    logic             r_frame_tick;

    logic             w_slot_edge;
    logic             w_frame_load;
    logic [3:0]       w_digit;
    logic             w_blank;
    logic [6:0]       w_seg;
    logic [3:0]       w_dig_sel;
    logic             w_dp;

    assign w_slot_edge = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_idx <= SLOT0;
            r_cnt <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            r_cnt <= w_slot_edge ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_slot_edge) begin
            case (r_idx)
                SLOT0:   w_idx_nxt = SLOT1;
                SLOT1:   w_idx_nxt = SLOT2;
                SLOT2:   w_idx_nxt = SLOT3;
                default: w_idx_nxt = SLOT0;
            endcase
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        w_frame_load = w_slot_edge && (r_idx == SLOT3);
        w_digit      = r_snap[r_idx];
        w_dp         = ~r_dp_snap[r_idx];
        w_dig_sel    = (bus.en && (r_cnt >= BLANK_TH)) ? ~(4'b0001 << r_idx) : 4'hF;
        w_blank      = 1'b0;
        case (r_idx)
            SLOT3:   w_blank = (r_snap[3] == 4'd0);
            SLOT2:   w_blank = (r_snap[3] == 4'd0) && (r_snap[2] == 4'd0);
            SLOT1:   w_blank = (r_snap[3] == 4'd0) && (r_snap[2] == 4'd0) && (r_snap[1] == 4'd0);
            default: w_blank = 1'b0;
        endcase
        case (w_digit)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: w_seg = 7'h3F;
        endcase
        if (BLANK_LZ && w_blank) begin
            w_seg = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_snap    <= '0;
            r_dp_snap <= '0;
        end else if (w_frame_load) begin
            r_snap    <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
            r_dp_snap <= bus.dp_mask;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_seg_out    <= 7'h7F;
            r_dp_out     <= 1'b1;
            r_dig_sel    <= 4'hF;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg_out    <= w_seg;
            r_dp_out     <= w_dp;
            r_dig_sel    <= w_dig_sel;
            r_frame_tick <= w_frame_load;
        end
    end

    assign bus.seg_out    = r_seg_out;
    assign bus.dp_out     = r_dp_out;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: a cycle-count based reference pushes expected outputs
// into a queue before each edge; they are popped and compared after the edge.
module tb_seg_scan;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FR = 4 * SD;
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
        logic [6:0] seg_nolz;
        logic       dp;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   k = 0;
    logic [3:0] m_snap [4];
    logic [3:0] m_dp;
    exp_t q [$];

    seg_scan_if ifa ();
    seg_scan_if ifb ();

    assign ifb.en      = ifa.en;
    assign ifb.digit0  = ifa.digit0;
    assign ifb.digit1  = ifa.digit1;
    assign ifb.digit2  = ifa.digit2;
    assign ifb.digit3  = ifa.digit3;
    assign ifb.dp_mask = ifa.dp_mask;

    seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .bus(ifa.slave));
    seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(1'b0)) u_dut_nolz (
        .clk(clk), .sys_rst_n(sys_rst_n), .bus(ifb.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int i, input bit lz_en);
        bit all0 = 1'b1;
        for (int j = i; j < 4; j++) if (m_snap[j] != 4'd0) all0 = 1'b0;
        if (lz_en && i != 0 && all0) return 7'h7F;
        return SEG_TBL[m_snap[i]];
    endfunction

    task automatic model_reset();
        k = 0;
        m_dp = 4'h0;
        for (int j = 0; j < 4; j++) m_snap[j] = 4'h0;
    endtask

    task automatic step();
        exp_t e;
        int c, i;
        k++;
        c = (k - 1) % SD;
        i = ((k - 1) / SD) % 4;
        e.dig      = (ifa.en && c >= BC) ? ~(4'b0001 << i) : 4'hF;
        e.seg      = exp_seg(i, 1'b1);
        e.seg_nolz = exp_seg(i, 1'b0);
        e.dp       = ~m_dp[i];
        e.ft       = (k % FR) == 0;
        q.push_back(e);
        if (e.ft) begin
            m_snap[0] = ifa.digit0;
            m_snap[1] = ifa.digit1;
            m_snap[2] = ifa.digit2;
            m_snap[3] = ifa.digit3;
            m_dp      = ifa.dp_mask;
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("dig_sel", 32'(ifa.dig_sel), 32'(e.dig));
        chk("seg_out", 32'(ifa.seg_out), 32'(e.seg));
        chk("dp_out", 32'(ifa.dp_out), 32'(e.dp));
        chk("frame_tick", 32'(ifa.frame_tick), 32'(e.ft));
        chk("seg_out_nolz", 32'(ifb.seg_out), 32'(e.seg_nolz));
    endtask

    task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0);
        ifa.digit3 = d3;
        ifa.digit2 = d2;
        ifa.digit1 = d1;
        ifa.digit0 = d0;
    endtask

    initial begin
        ifa.en = 1'b1;
        ifa.dp_mask = 4'h0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(ifa.seg_out), 32'h7F);
        chk("rst_dp", 32'(ifa.dp_out), 32'h1);
        chk("rst_dig", 32'(ifa.dig_sel), 32'hF);
        chk("rst_ft", 32'(ifa.frame_tick), 32'h0);

        // Basic scan: first frame shows "   0", then 1 2 3 0.
        set_digits(4'd1, 4'd2, 4'd3, 4'd0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        model_reset();
        repeat (3 * FR) step();

        // Leading zeros with a decimal point on a blanked digit.
        set_digits(4'd0, 4'd0, 4'd5, 4'd0);
        ifa.dp_mask = 4'b0100;
        repeat (2 * FR) step();

        // Invalid code on digit2.
        set_digits(4'd0, 4'hC, 4'd5, 4'd0);
        repeat (2 * FR) step();

        // Tear-free: digit0 changes 7 -> 8 mid-frame while idx==1.
        set_digits(4'd0, 4'd0, 4'd0, 4'd7);
        ifa.dp_mask = 4'h0;
        repeat (FR) step();
        repeat (5) step();
        ifa.digit0 = 4'd8;
        repeat (FR + FR - 5) step();

        // en dropped mid-slot, restored coincident with a slot edge.
        repeat (6) step();
        ifa.en = 1'b0;
        repeat (5) step();
        ifa.en = 1'b1;
        repeat (12) step();

        // Reset mid-frame.
        while ((k % FR) != 6) step();
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_seg", 32'(ifa.seg_out), 32'h7F);
        chk("midrst_dp", 32'(ifa.dp_out), 32'h1);
        chk("midrst_dig", 32'(ifa.dig_sel), 32'hF);
        chk("midrst_ft", 32'(ifa.frame_tick), 32'h0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        model_reset();
        repeat (FR + 4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
